// File: rtl/tc_pkg.sv
// Shared definitions for the m_timer countdown timer: register offsets, CTRL fields,
// MODE encodings and FSM states. CTRL[7:4] (PSC) exists only when TC_PRESCALE_EN is defined.
package tc_pkg;

    // Register offsets within the 16-byte window, selected by addr[3:2]
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;
    localparam int unsigned CTRL_PSC_LO  = 4;
    localparam int unsigned CTRL_PSC_HI  = 7;

    // MODE encodings; 2'b1x behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

`ifdef TC_PRESCALE_EN
    localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
    localparam logic [7:0] CTRL_MASK = 8'h0F;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } tc_state_e;

    // Replace each byte of cur whose enable is set with the matching byte of wdata
    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  byteen);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/m_tc_prescaler.sv
// Prescale counter for m_timer: ticks once every psc+1 cycles while run is high,
// and sits at zero whenever run is low.
module m_tc_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] psc,
    output logic       tick
);

    logic [3:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == psc);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/m_timer.sv
// Memory-mapped countdown timer on the M-stage data bus with interrupt to CP0.
// Optional prescaler on CTRL[7:4] is enabled by defining TC_PRESCALE_EN.
module m_timer
    import tc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        irq
);

    tc_state_e   state_q, state_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic hit;
    logic wr;
    logic wr_ctrl;
    logic wr_preset;
    logic en;
    logic auto_mode;
    logic run;
    logic tick;
    logic set_flag;
    logic unused_addr;

    assign unused_addr = ^addr[1:0];

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr        = hit && (byteen != 4'b0000);
    assign wr_ctrl   = wr && (addr[3:2] == TC_CTRL);
    assign wr_preset = wr && (addr[3:2] == TC_PRESET);

    assign en        = ctrl_q[CTRL_EN];
    assign auto_mode = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);
    assign run       = (state_q == CNT) && en;

`ifdef TC_PRESCALE_EN
    m_tc_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .psc   (ctrl_q[CTRL_PSC_HI:CTRL_PSC_LO]),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        set_flag   = 1'b0;

        // A cleared EN pulls every active state back to IDLE on the next edge
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    count_d = preset_q;
                    state_d = CNT;
                end
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (count_q == 32'd0) begin
                        state_d  = INT;
                        set_flag = 1'b1;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end
            end
            INT: begin
                if (auto_mode) begin
                    irq_flag_d = 1'b0;
                end
                if (!en) begin
                    state_d = IDLE;
                end else if (auto_mode) begin
                    state_d = LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus writes override the one-shot EN auto-clear; a fresh INT entry beats the clear
        if (wr_ctrl || wr_preset) begin
            irq_flag_d = 1'b0;
        end
        if (set_flag) begin
            irq_flag_d = 1'b1;
        end
        if (wr_ctrl && byteen[0]) begin
            ctrl_d = wdata[7:0] & CTRL_MASK;
        end
        if (wr_preset) begin
            preset_d = byte_merge(preset_q, wdata, byteen);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= 8'h00;
            preset_q   <= 32'h0;
            count_q    <= 32'h0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            unique case (addr[3:2])
                TC_CTRL:   rdata = {24'h0, ctrl_q & CTRL_MASK};
                TC_PRESET: rdata = preset_q;
                TC_COUNT:  rdata = count_q;
                default:   rdata = 32'h0;
            endcase
        end
    end

    assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_m_timer.sv
// Directed self-checking bench for m_timer: reset, byte merge, window decode,
// one-shot, auto-reload, mid-count disable and PRESET=0 with reset while irq is high.
`timescale 1ns/1ps
module tb_m_timer;
    import tc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    m_timer #(
        .BASE_ADDR (32'h0000_7F00)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Leaves the bench 1ns after the next rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one write for exactly one rising edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr   = a;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        #1;
        byteen = 4'b0000;
        wdata  = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset  = 1'b1;
        addr   = 32'h0;
        wdata  = 32'h0;
        byteen = 4'b0000;
        step(2);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got %b want 0", irq);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++; $display("FAIL reset_state got %0d want IDLE", dut.state_q);
        end
        bus_read(32'h7F00, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
        bus_read(32'h7F04, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_preset got %h want 0", d); end
        bus_read(32'h7F08, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_count got %h want 0", d); end
        @(negedge clk);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_byte_merge;
        logic [31:0] d;
        logic [31:0] exp_ctrl;
        bus_write(32'h7F04, 32'h11223344, 4'b1111);
        bus_read(32'h7F04, d);
        checks++;
        if (d !== 32'h11223344) begin
            errors++; $display("FAIL preset_full got %h want 11223344", d);
        end
        bus_write(32'h7F05, 32'h0000AA00, 4'b0010);
        bus_read(32'h7F04, d);
        checks++;
        if (d !== 32'h1122AA44) begin
            errors++; $display("FAIL preset_merge got %h want 1122aa44", d);
        end
        bus_write(32'h7F08, 32'hFFFFFFFF, 4'b1111);
        bus_read(32'h7F08, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL count_ro got %h want 0", d); end
        bus_write(32'h7F0C, 32'hFFFFFFFF, 4'b1111);
        bus_read(32'h7F0C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reserved got %h want 0", d); end
        // Only EN..IM (and PSC when present) are storage; EN stays 0 here
        bus_write(32'h7F00, 32'hFFFFFFF0, 4'b1111);
`ifdef TC_PRESCALE_EN
        exp_ctrl = 32'h000000F0;
`else
        exp_ctrl = 32'h00000000;
`endif
        bus_read(32'h7F00, d);
        checks++;
        if (d !== exp_ctrl) begin
            errors++; $display("FAIL ctrl_mask got %h want %h", d, exp_ctrl);
        end
        bus_write(32'h7F00, 32'h0000000F, 4'b1110);
        bus_read(32'h7F00, d);
        checks++;
        if (d !== exp_ctrl) begin
            errors++; $display("FAIL ctrl_lane0_gate got %h want %h", d, exp_ctrl);
        end
        bus_write(32'h7F00, 32'h0, 4'b1111);
    endtask

    task automatic test_non_hit;
        logic [31:0] d;
        bus_write(32'h7E00, 32'hFFFFFFFF, 4'b1111);
        bus_write(32'h8000, 32'hFFFFFFFF, 4'b1111);
        bus_write(32'h7F14, 32'hFFFFFFFF, 4'b1111);
        bus_read(32'h7E00, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL miss_rd_7e00 got %h want 0", d); end
        bus_read(32'h8000, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL miss_rd_8000 got %h want 0", d); end
        bus_read(32'h7F00, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL miss_ctrl got %h want 0", d); end
        bus_read(32'h7F04, d);
        checks++;
        if (d !== 32'h1122AA44) begin
            errors++; $display("FAIL miss_preset got %h want 1122aa44", d);
        end
        step(3);
        bus_read(32'h7F08, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL miss_count got %h want 0", d); end
    endtask

    task automatic test_one_shot;
        logic [31:0] d;
        logic [31:0] exp_cnt [1:5];
        exp_cnt[1] = 32'd0;
        exp_cnt[2] = 32'd3;
        exp_cnt[3] = 32'd2;
        exp_cnt[4] = 32'd1;
        exp_cnt[5] = 32'd0;
        bus_write(32'h7F04, 32'd3, 4'b1111);
        bus_write(32'h7F00, 32'h9, 4'b1111);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            bus_read(32'h7F08, d);
            checks++;
            if (d !== exp_cnt[k] || irq !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_e%0d count %0d irq %b want count %0d irq 0",
                         k, d, irq, exp_cnt[k]);
            end
        end
        step(1);
        bus_read(32'h7F00, d);
        checks++;
        if (irq !== 1'b1 || d !== 32'h9) begin
            errors++; $display("FAIL oneshot_e6 irq %b ctrl %h want irq 1 ctrl 9", irq, d);
        end
        step(1);
        bus_read(32'h7F00, d);
        checks++;
        if (irq !== 1'b1 || d !== 32'h8) begin
            errors++; $display("FAIL oneshot_e7 irq %b ctrl %h want irq 1 ctrl 8", irq, d);
        end
        step(3);
        bus_read(32'h7F08, d);
        checks++;
        if (irq !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL oneshot_hold irq %b count %h want irq 1 count 0", irq, d);
        end
        bus_write(32'h7F00, 32'h8, 4'b1111);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL oneshot_clear irq %b want 0", irq);
        end
    endtask

    task automatic test_auto_reload;
        logic exp_flag;
        bus_write(32'h7F04, 32'd2, 4'b1111);
        bus_write(32'h7F00, 32'hB, 4'b1111);
        for (int k = 1; k <= 15; k++) begin
            step(1);
            checks++;
            if (irq !== ((k % 5) == 0)) begin
                errors++; $display("FAIL auto_irq_e%0d got %b want %b", k, irq, (k % 5) == 0);
            end
        end
        // IM=0 keeps reloading; the flag still pulses at e20 and e25
        bus_write(32'h7F00, 32'h3, 4'b1111);
        for (int k = 17; k <= 26; k++) begin
            step(1);
            exp_flag = (k == 20) || (k == 25);
            checks++;
            if (irq !== 1'b0 || dut.irq_flag_q !== exp_flag) begin
                errors++;
                $display("FAIL auto_masked_e%0d irq %b flag %b want irq 0 flag %b",
                         k, irq, dut.irq_flag_q, exp_flag);
            end
        end
        bus_write(32'h7F00, 32'h0, 4'b1111);
        step(2);
    endtask

    task automatic test_disable_mid_count;
        logic [31:0] d;
        bus_write(32'h7F04, 32'd10, 4'b1111);
        bus_write(32'h7F00, 32'h1, 4'b1111);
        step(5);
        bus_read(32'h7F08, d);
        checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL dis_pre got %0d want 7", d); end
        // EN=0 lands on the same edge as the last decrement, so COUNT settles at 6
        bus_write(32'h7F00, 32'h0, 4'b1111);
        bus_read(32'h7F08, d);
        checks++;
        if (d !== 32'd6) begin errors++; $display("FAIL dis_edge got %0d want 6", d); end
        step(3);
        bus_read(32'h7F08, d);
        checks++;
        if (d !== 32'd6 || irq !== 1'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL dis_hold count %0d irq %b state %0d want 6 0 IDLE",
                     d, irq, dut.state_q);
        end
        bus_write(32'h7F08, 32'hFFFFFFFF, 4'b1111);
        bus_read(32'h7F08, d);
        checks++;
        if (d !== 32'd6) begin errors++; $display("FAIL dis_count_ro got %0d want 6", d); end
    endtask

    task automatic test_preset_zero_reset;
        logic [31:0] d;
        bus_write(32'h7F04, 32'd0, 4'b1111);
        bus_write(32'h7F00, 32'h9, 4'b1111);
        step(2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL pz_e2 irq %b want 0", irq); end
        step(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pz_e3 irq %b want 1", irq); end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b0 || dut.state_q !== IDLE) begin
            errors++; $display("FAIL rst_mid irq %b state %0d want 0 IDLE", irq, dut.state_q);
        end
        bus_read(32'h7F00, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_ctrl got %h want 0", d); end
        bus_read(32'h7F04, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_preset got %h want 0", d); end
        @(negedge clk);
        reset = 1'b0;
        step(3);
        bus_read(32'h7F08, d);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL rst_after count %h irq %b want 0 0", d, irq);
        end
    endtask

    initial begin
        test_reset();
        test_byte_merge();
        test_non_hit();
        test_one_shot();
        test_auto_reload();
        test_disable_mid_count();
        test_preset_zero_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
